// File: rtl/isr_shifter_pkg.sv
// Shared PIO definitions: widths, ISR FSM states,
// and the 0-means-32 field decode.
package isr_shifter_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_AUTO_PEND = 1'b1
  } isr_state_e;

  // 5-bit count fields encode 32 as 0
  function automatic logic [CNT_W-1:0] eff_width(
    input logic [4:0] v
  );
    return (v == 5'd0) ? CNT_W'(DATA_W) : {1'b0, v};
  endfunction

endpackage

// File: rtl/isr_shifter_merge.sv
// ISR shift/merge datapath for one IN instruction.
// n is 1..32; n = 32 replaces the ISR with din.
module isr_merge
  import isr_shifter_pkg::*;
(
  input  logic [DATA_W-1:0] i_isr,
  input  logic [DATA_W-1:0] i_din,
  input  logic [CNT_W-1:0]  i_n,
  input  logic              i_dir,
  output logic [DATA_W-1:0] o_isr
);

  logic              w_full;
  logic [4:0]        w_sh;
  logic [4:0]        w_rsh;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_din;

  assign w_full = (i_n == CNT_W'(DATA_W));
  assign w_sh   = i_n[4:0];
  assign w_rsh  = 5'd0 - w_sh;

  // Keep only the low n source bits, then merge
  always_comb begin
    w_mask = '1;
    if (!w_full)
      w_mask = (32'd1 << w_sh) - 32'd1;
    w_din = i_din & w_mask;
    o_isr = w_din;
    if (!w_full) begin
      if (i_dir)
        o_isr = (i_isr >> w_sh) | (w_din << w_rsh);
      else
        o_isr = (i_isr << w_sh) | w_din;
    end
  end

endmodule

// File: rtl/isr_shifter.sv
// PIO input shift register with explicit/auto push.
// Optional ISR_DROP_COUNT_EN adds drop_count output.
module isr_shifter
  import isr_shifter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              stalled,
  input  logic [DATA_W-1:0] din,
  input  logic [4:0]        shift,
  input  logic              dir,
  input  logic              do_in,
  input  logic              do_push,
  input  logic              push_block,
  input  logic              push_iffull,
  input  logic              auto_push,
  input  logic [4:0]        thresh,
  input  logic              clear,
  input  logic              rx_full,
  output logic              push,
  output logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] isr,
  output logic [CNT_W-1:0]  shift_count,
`ifdef ISR_DROP_COUNT_EN
  output logic [7:0]        drop_count,
`endif
  output logic              stall_out
);

  isr_state_e        r_state;
  logic [DATA_W-1:0] r_isr;
  logic [CNT_W-1:0]  r_count;
  logic              r_push;
  logic [DATA_W-1:0] r_push_data;
`ifdef ISR_DROP_COUNT_EN
  logic [7:0]        r_drop;
`endif

  logic [CNT_W-1:0]  w_n;
  logic [CNT_W-1:0]  w_t;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] w_merged;
  logic              w_idle_act;
  logic              w_push_skip;
  logic              w_blk_stall;

  assign w_n = eff_width(shift);
  assign w_t = eff_width(thresh);

  assign w_sum = {1'b0, r_count} + {1'b0, w_n};
  assign w_cnt_next = (w_sum > (CNT_W+1)'(DATA_W))
                    ? CNT_W'(DATA_W) : w_sum[CNT_W-1:0];

  isr_merge u_merge (
    .i_isr (r_isr),
    .i_din (din),
    .i_n   (w_n),
    .i_dir (dir),
    .o_isr (w_merged)
  );

  assign w_idle_act = (r_state == ST_IDLE) && penable
                    && !stalled && !clear;
  assign w_push_skip = push_iffull && (r_count < w_t);
  assign w_blk_stall = w_idle_act && do_push
                     && !w_push_skip && rx_full
                     && push_block;

  assign stall_out = !reset
    && (((r_state == ST_AUTO_PEND) && rx_full)
        || w_blk_stall);

  assign push        = r_push;
  assign push_data   = r_push_data;
  assign isr         = r_isr;
  assign shift_count = r_count;
`ifdef ISR_DROP_COUNT_EN
  assign drop_count  = r_drop;
`endif

  // ISR FSM: IN accumulation, push handling, autopush wait
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_isr       <= '0;
      r_count     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
`ifdef ISR_DROP_COUNT_EN
      r_drop      <= '0;
`endif
    end else begin
      r_push <= 1'b0;
      if (penable) begin
        unique case (r_state)
          ST_IDLE: begin
            if (!stalled) begin
              if (clear) begin
                r_isr   <= '0;
                r_count <= '0;
              end else if (do_push) begin
                if (!w_push_skip) begin
                  if (!rx_full) begin
                    r_push      <= 1'b1;
                    r_push_data <= r_isr;
                    r_isr       <= '0;
                    r_count     <= '0;
                  end else if (!push_block) begin
                    r_isr   <= '0;
                    r_count <= '0;
`ifdef ISR_DROP_COUNT_EN
                    if (r_drop != 8'hFF)
                      r_drop <= r_drop + 8'd1;
`endif
                  end
                end
              end else if (do_in) begin
                r_isr   <= w_merged;
                r_count <= w_cnt_next;
                if (auto_push && (w_cnt_next >= w_t))
                  r_state <= ST_AUTO_PEND;
              end
            end
          end
          ST_AUTO_PEND: begin
            if (clear) begin
              r_isr   <= '0;
              r_count <= '0;
              r_state <= ST_IDLE;
            end else if (!rx_full) begin
              r_push      <= 1'b1;
              r_push_data <= r_isr;
              r_isr       <= '0;
              r_count     <= '0;
              r_state     <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_isr_shifter.sv
// Scoreboard bench for isr_shifter: directed
// scenarios then random traffic vs a word model.
module tb_isr_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        penable;
  logic        stalled;
  logic [31:0] din;
  logic [4:0]  shift;
  logic        dir;
  logic        do_in;
  logic        do_push;
  logic        push_block;
  logic        push_iffull;
  logic        auto_push;
  logic [4:0]  thresh;
  logic        clear;
  logic        rx_full;
  logic        push;
  logic [31:0] push_data;
  logic [31:0] isr;
  logic [5:0]  shift_count;
  logic        stall_out;
`ifdef ISR_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  always #5 clk = ~clk;

  isr_shifter dut (
    .clk         (clk),
    .reset       (reset),
    .penable     (penable),
    .stalled     (stalled),
    .din         (din),
    .shift       (shift),
    .dir         (dir),
    .do_in       (do_in),
    .do_push     (do_push),
    .push_block  (push_block),
    .push_iffull (push_iffull),
    .auto_push   (auto_push),
    .thresh      (thresh),
    .clear       (clear),
    .rx_full     (rx_full),
    .push        (push),
    .push_data   (push_data),
    .isr         (isr),
    .shift_count (shift_count),
`ifdef ISR_DROP_COUNT_EN
    .drop_count  (drop_count),
`endif
    .stall_out   (stall_out)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_isr = '0;
  int          m_cnt = 0;
  bit          m_pend = 0;
  int          m_drop = 0;
  bit          m_push_exp = 0;
  logic [31:0] sb_q[$];
  logic [31:0] got[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int width_of(input logic [4:0] v);
    return (v == 0) ? 32 : int'(v);
  endfunction

  function automatic bit exp_stall();
    int t;
    t = width_of(thresh);
    if (reset) return 0;
    if (m_pend) return rx_full;
    return penable && !stalled && !clear && do_push
        && !(push_iffull && m_cnt < t)
        && rx_full && push_block;
  endfunction

  // spec-level IN: 64-bit shift-and-or, saturating count
  task automatic model_in();
    int n;
    logic [63:0] dv;
    logic [63:0] r;
    n  = width_of(shift);
    dv = {32'd0, din} & ((64'd1 << n) - 64'd1);
    if (dir)
      r = ({32'd0, m_isr} >> n) | (dv << (32 - n));
    else
      r = ({32'd0, m_isr} << n) | dv;
    m_isr = r[31:0];
    m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
  endtask

  task automatic model_emit();
    sb_q.push_back(m_isr);
    m_push_exp = 1;
    m_isr = '0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    int t;
    t = width_of(thresh);
    m_push_exp = 0;
    if (reset) begin
      m_isr = '0; m_cnt = 0; m_pend = 0; m_drop = 0;
    end else if (penable) begin
      if (m_pend) begin
        if (clear) begin
          m_isr = '0; m_cnt = 0; m_pend = 0;
        end else if (!rx_full) begin
          model_emit();
          m_pend = 0;
        end
      end else if (!stalled) begin
        if (clear) begin
          m_isr = '0; m_cnt = 0;
        end else if (do_push) begin
          if (push_iffull && m_cnt < t) begin
          end else if (!rx_full) begin
            model_emit();
          end else if (!push_block) begin
            m_isr = '0; m_cnt = 0;
            if (m_drop < 255) m_drop++;
          end
        end else if (do_in) begin
          model_in();
          if (auto_push && m_cnt >= t) m_pend = 1;
        end
      end
    end
  endtask

  // one clock: check comb stall, edge, check state
  task automatic step();
    #2;
    chk("stall_out", {31'd0, stall_out},
        {31'd0, exp_stall()});
    @(posedge clk);
    model_edge();
    #1;
    chk("isr", isr, m_isr);
    chk("shift_count", {26'd0, shift_count}, 32'(m_cnt));
`ifdef ISR_DROP_COUNT_EN
    chk("drop_count", {24'd0, drop_count}, 32'(m_drop));
`endif
  endtask

  // monitor: strobe and scoreboard pop on each push
  always @(negedge clk) begin
    chk("push_strobe", {31'd0, push}, {31'd0, m_push_exp});
    if (push === 1'b1) begin
      got.push_back(push_data);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL push_unexpected actual=%h required=none",
                 push_data);
      end else begin
        chk("push_data", push_data, sb_q.pop_front());
      end
    end
  end

  task automatic quiet();
    reset = 0; penable = 1; stalled = 0;
    do_in = 0; do_push = 0; clear = 0;
    push_block = 0; push_iffull = 0;
    auto_push = 0; rx_full = 0;
  endtask

  initial begin
    quiet();
    din = '0; shift = 5'd8; dir = 0; thresh = 5'd0;
    reset = 1;
    step();
    step();
    reset = 0;
    chk("rst_push", {31'd0, push}, 32'd0);
    chk("rst_push_data", push_data, 32'd0);
    chk("rst_isr", isr, 32'd0);

    // left IN accumulation
    dir = 0; shift = 5'd8; do_in = 1;
    din = 32'hFFFF_FFA5; step();
    din = 32'h0000_013C; step();
    do_in = 0;
    chk("left_isr", isr, 32'h0000_A53C);
    chk("left_cnt", {26'd0, shift_count}, 32'd16);

    // right IN with autopush at 16
    clear = 1; step(); clear = 0;
    got.delete();
    dir = 1; thresh = 5'd16; auto_push = 1;
    for (int i = 1; i <= 4; i++) begin
      din = 32'(i * 8'h11); do_in = 1; step();
      do_in = 0; step();
    end
    step();
    chk("auto_n", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("auto_w0", got[0], 32'h2211_0000);
      chk("auto_w1", got[1], 32'h4433_0000);
    end
    chk("auto_cnt", {26'd0, shift_count}, 32'd0);
    auto_push = 0;

    // blocking push held off by full FIFO
    got.delete();
    dir = 0; shift = 5'd16; din = 32'h1234_BEEF;
    do_in = 1; step(); do_in = 0;
    do_push = 1; push_block = 1; rx_full = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blk_stall", {31'd0, stall_out}, 32'd1);
      chk("blk_isr", isr, 32'h0000_BEEF);
    end
    rx_full = 0; step();
    do_push = 0; push_block = 0; step();
    chk("blk_n", 32'(got.size()), 32'd1);
    if (got.size() == 1)
      chk("blk_word", got[0], 32'h0000_BEEF);

    // nonblocking push dropped on full FIFO
    shift = 5'd8; din = 32'h77; do_in = 1; step();
    do_in = 0; do_push = 1; rx_full = 1; step();
    do_push = 0; rx_full = 0;
    chk("drop_isr", isr, 32'd0);
    chk("drop_cnt", {26'd0, shift_count}, 32'd0);
`ifdef ISR_DROP_COUNT_EN
    chk("drop_count1", {24'd0, drop_count}, 32'd1);
`endif

    // push_iffull below and at threshold 24
    got.delete();
    thresh = 5'd24; shift = 5'd8; do_in = 1;
    din = 32'h1; step();
    din = 32'h2; step();
    do_in = 0; do_push = 1; push_iffull = 1; step();
    do_push = 0;
    chk("iff_keep", isr, 32'h0000_0102);
    chk("iff_cnt", {26'd0, shift_count}, 32'd16);
    din = 32'h3; do_in = 1; step(); do_in = 0;
    do_push = 1; step(); do_push = 0; push_iffull = 0;
    step();
    chk("iff_n", 32'(got.size()), 32'd1);
    if (got.size() == 1)
      chk("iff_word", got[0], 32'h0001_0203);

    // reset, then clear, while autopush is pending
    for (int k = 0; k < 2; k++) begin
      got.delete();
      thresh = 5'd8; auto_push = 1; rx_full = 1;
      din = 32'h5A; do_in = 1; step(); do_in = 0;
      step(); step();
      chk("pend_stall", {31'd0, stall_out}, 32'd1);
      if (k == 0) reset = 1; else clear = 1;
      step();
      reset = 0; clear = 0;
      step();
      rx_full = 0;
      step(); step();
      chk("abort_stall", {31'd0, stall_out}, 32'd0);
      chk("abort_nopush", 32'(got.size()), 32'd0);
      chk("abort_cnt", {26'd0, shift_count}, 32'd0);
      auto_push = 0;
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      penable     = ($urandom_range(0, 7) != 0);
      stalled     = ($urandom_range(0, 9) == 0);
      do_in       = $urandom_range(0, 1) == 1;
      do_push     = ($urandom_range(0, 6) == 0);
      clear       = ($urandom_range(0, 39) == 0);
      push_block  = $urandom_range(0, 1) == 1;
      push_iffull = ($urandom_range(0, 3) == 0);
      auto_push   = $urandom_range(0, 1) == 1;
      rx_full     = ($urandom_range(0, 2) == 0);
      dir         = $urandom_range(0, 1) == 1;
      shift       = 5'($urandom);
      thresh      = 5'($urandom);
      din         = $urandom;
      step();
    end
    quiet();
    step(); step();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/isr_shifter.md
Name: isr_shifter

Overview:
- Input shift register (ISR) for a PIO state machine: the receive-direction counterpart of the output shifter.
- Accumulates pin/source bits on IN instructions and tracks the bit count.
- Hands completed words to the RX FIFO through explicit PUSH or autopush at a programmable threshold.
- Generates the state-machine stall when a blocking or automatic push meets a full RX FIFO.

Parameters:
- None. Data width is fixed at 32; count width is fixed at 6.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- penable  in  1  clock-divider enable; state advances only when high
- stalled  in  1  SM stalled for an external reason; suppresses new instructions
- din  in  32  IN source data; low `shift` bits used
- shift  in  5  IN bit count; 0 means 32
- dir  in  1  1 = shift right (bits enter at MSB), 0 = shift left (bits enter at LSB)
- do_in  in  1  execute IN this cycle
- do_push  in  1  execute PUSH this cycle
- push_block  in  1  PUSH stalls when FIFO full (else data dropped)
- push_iffull  in  1  PUSH only if count >= threshold
- auto_push  in  1  autopush enable
- thresh  in  5  push threshold; 0 means 32
- clear  in  1  zero ISR and count (MOV ISR / SM restart)
- rx_full  in  1  RX FIFO full
- push  out  1  single-cycle FIFO write strobe
- push_data  out  32  word written on push
- isr  out  32  current ISR contents
- shift_count  out  6  bits held, 0..32
- stall_out  out  1  push-induced stall request

Behaviour:
- Reset:
  - isr = 0, count = 0, state = IDLE
  - push = 0, push_data = 0, stall_out = 0
- Effective widths:
  - n = (shift == 0) ? 32 : shift
  - t = (thresh == 0) ? 32 : thresh
- IN arithmetic:
  - Right: isr' = (isr >> n) | (din[n-1:0] << (32-n))
  - Left: isr' = (isr << n) | din[n-1:0]
  - Computed in 64 bits so that n = 32 fully replaces isr.
  - count' = min(count + n, 32), saturating.
- No state changes and no push when penable = 0. push is a registered one-cycle pulse; push_data is registered with it.
- FSM states: IDLE, AUTO_PEND.
- IDLE (penable = 1, stalled = 0). Priority order: clear > do_push > do_in.
  - clear: isr = 0, count = 0.
  - do_push:
    - If push_iffull and count < t: no-op.
    - Else if !rx_full: push = 1, push_data = isr, then isr = 0, count = 0.
    - Else if push_block: stall_out = 1 (combinational), ISR unchanged; SM retries next cycle.
    - Else (nonblocking, full): data dropped, isr = 0, count = 0, push = 0.
  - do_in: apply IN. If auto_push and count' >= t, go to AUTO_PEND.
- AUTO_PEND:
  - stall_out = 1 whenever rx_full.
  - On each penable cycle with !rx_full: push = 1, push_data = isr, isr = 0, count = 0, go to IDLE; stall_out = 0 that cycle.
  - Ignores do_in, do_push and stalled. clear still aborts to IDLE with no push.
- Boundaries:
  - count already 32 with IN: shift still occurs, count stays 32.
  - thresh = 0 with auto_push: push after each 32 accumulated bits.
  - Reset mid-AUTO_PEND: returns to IDLE, pending word discarded.
  - stalled = 1 in IDLE: all instruction inputs ignored.

Optional Feature:
- Macro: ISR_DROP_COUNT_EN.
- With the macro defined:
  - Extra output drop_count [7:0], reset 0.
  - Increments (saturating at 255) on each nonblocking PUSH discarded due to rx_full.
  - clear does not affect it.
- Without the macro: the port is absent, with no extra logic.

Decomposition:
- Shared pio package holds:
  - fixed width constants DATA_W = 32, CNT_W = 6
  - the FSM state encoding for IDLE / AUTO_PEND
  - helper functions for the 0-means-32 decode used here and in the OUT shifter
- The shift/merge datapath is a natural combinational sub-module, isr_merge (isr, din, n, dir -> isr').
- FSM and counters stay in the top module.

Test Plan:
- Left IN: shift = 8, din = 0xA5, then 0x3C, dir = 0 -> isr = 0x0000A53C, count = 16.
- Right autopush: dir = 1, thresh = 16, four IN with shift = 8 and din = 0x11, 0x22, 0x33, 0x44.
  - Push after the 2nd IN with push_data = 0x22110000.
  - Second push with push_data = 0x44330000.
  - count = 0 after each push.
- Blocking PUSH, rx_full = 1 for 3 cycles then 0:
  - stall_out = 1 for those 3 cycles.
  - push pulses on the 4th cycle with the unchanged ISR.
- Nonblocking PUSH with rx_full = 1:
  - no push, isr = 0, count = 0.
  - drop_count = 1 when ISR_DROP_COUNT_EN is defined.
- push_iffull with thresh = 24 and count = 16: no push, ISR retained. Same after count reaches 24: push occurs.
- Reset or clear during AUTO_PEND (rx_full held 1): state returns to IDLE, stall_out = 0, no push ever issued for that word.
